cordic_arbiter: RTL

Round-robin scheduler that shares one iterative sine/cosine CORDIC engine among NUM_REQ independent requesters. It accepts one angle at a time through per-requester valid/ready handshakes, issues a single-cycle start to the engine, and waits for its done pulse. It then returns the cosine/sine pair on a shared, ID-tagged response port. The block sits between the DSP clients (NCOs, rotators) and the single CORDIC instance.

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_arbiter_rr_arbiter.sv | 39 +++
 rtl/cordic_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC arbiter slice.
// Holds the FSM state enum, angle constants and fixed-point widths.
package cordic_pkg;

  localparam int COORD_W = 16;
  localparam int ANGLE_W = 32;

  localparam logic [31:0] PI_2 = 32'h3243F6A9;
  localparam logic [31:0] PI   = 32'h6487ED51;

  localparam logic [15:0] CORDIC_GAIN = 16'h26DD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/cordic_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req at or above ptr.
// Ports: req_i, ptr_i in; gnt_o (one-hot), gnt_id_o, any_o out.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_id_o,
  output logic               any_o
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    any_o    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // ptr + i stays below 2*NUM_REQ, so one subtract wraps it
      sum = {1'b0, ptr_i} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ))
        sum = sum - (IDW+1)'(NUM_REQ);
      idx = sum[IDW-1:0];
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one iterative CORDIC engine among NUM_REQ clients.
// Ports: req_* valid/ready/angle in, resp_* tagged result out, eng_* engine side.
// Optional watchdog in WAIT: define CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter  int                NUM_REQ        = 4,
  parameter  int                WIDTH          = COORD_W,
  parameter  int                ANGLE_WIDTH    = ANGLE_W,
  parameter  logic [WIDTH-1:0]  X_INIT         = CORDIC_GAIN,
  parameter  int                TIMEOUT_CYCLES = 64,
  localparam int                IDW            = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [IDW-1:0]                 resp_id,
  output logic [WIDTH-1:0]               resp_cos,
  output logic [WIDTH-1:0]               resp_sin,
  output logic                           resp_err,
  output logic                           eng_start,
  output logic [ANGLE_WIDTH-1:0]         eng_angle,
  output logic [WIDTH-1:0]               eng_x_start,
  output logic [WIDTH-1:0]               eng_y_start,
  input  logic [WIDTH-1:0]               eng_cosine,
  input  logic [WIDTH-1:0]               eng_sine,
  input  logic                           eng_done
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cordic_arbiter: bad parameters");
  end

  arb_state_e state_q, state_d;

  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [ANGLE_WIDTH-1:0] ang_q, ang_d, sel_ang;
  logic [WIDTH-1:0]       cos_q, cos_d;
  logic [WIDTH-1:0]       sin_q, sin_d;
  logic [NUM_REQ-1:0]     gnt;
  logic [IDW-1:0]         gnt_id;
  logic                   gnt_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  always_comb begin
    sel_ang = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i])
        sel_ang = req_angle[i*ANGLE_WIDTH +: ANGLE_WIDTH];
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          wd_hit;

  // cnt_q counts completed WAIT cycles; fires on the last allowed one
  assign wd_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_ISSUE)
      cnt_d = '0;
    else if (state_q == ST_WAIT)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    ang_d   = ang_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          id_d    = gnt_id;
          ang_d   = sel_ang;
`ifdef CORDIC_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          cos_d   = eng_cosine;
          sin_d   = eng_sine;
          state_d = ST_RESP;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (wd_hit) begin
          cos_d   = '0;
          sin_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (resp_ready) begin
          ptr_d   = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      ang_q   <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      ang_q   <= ang_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE) ? gnt : '0;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_id     = id_q;
  assign resp_cos    = cos_q;
  assign resp_sin    = sin_q;
  assign eng_start   = (state_q == ST_ISSUE);
  assign eng_angle   = ang_q;
  assign eng_x_start = X_INIT;
  assign eng_y_start = '0;

endmodule
